// File: rtl/rocket_race_if.sv
// Per-frame control and display bundle between the game controller, the
// rocket/score engine and the renderers.
interface rocket_race_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 9,
  parameter int SCORE_W     = 4
);
  // Timing contract: FRAME_TICK is a one-cycle strobe per frame; GAME_ON is a level;
  // CRASH may pulse on any cycle. Every engine output is a flop, valid the cycle after
  // the event that changed it, and there is no back-pressure.
  logic                           FRAME_TICK;
  logic                           GAME_ON;
  logic [NUM_PLAYERS-1:0]         UP_N;
  logic [NUM_PLAYERS-1:0]         DOWN_N;
  logic [NUM_PLAYERS-1:0]         CRASH;
  logic [NUM_PLAYERS*POS_W-1:0]   POS;
  logic [NUM_PLAYERS*SCORE_W-1:0] SCORE;
  logic [NUM_PLAYERS-1:0]         SCORE_PULSE;
  logic [NUM_PLAYERS-1:0]         CRASHED;
  logic [NUM_PLAYERS-1:0]         ROCKET_ON;
  logic [2*NUM_PLAYERS-1:0]       DBG_STATE;

  modport master (
    output FRAME_TICK, GAME_ON, UP_N, DOWN_N, CRASH,
    input  POS, SCORE, SCORE_PULSE, CRASHED, ROCKET_ON, DBG_STATE
  );

  modport slave (
    input  FRAME_TICK, GAME_ON, UP_N, DOWN_N, CRASH,
    output POS, SCORE, SCORE_PULSE, CRASHED, ROCKET_ON, DBG_STATE
  );
endinterface

// File: rtl/rocket_race_core.sv
// N-player rocket/score engine: per-channel IDLE/FLY/CRASH FSM advanced once per
// frame, with shared GAME_ON edge handling for score clear and return to attract.
module rocket_race_core #(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 9,
  parameter int TOP_LINE    = 16,
  parameter int BOTTOM_LINE = 240,
  parameter int STEP        = 1,
  parameter int SCORE_W     = 4,
  parameter int MAX_SCORE   = 9,
  parameter int CRASH_HOLD  = 60
) (
  input  logic          CLK_SRC,
  input  logic          RESET,
  rocket_race_if.slave  bus
);

  localparam int HOLD_W  = $clog2(CRASH_HOLD + 1);
  localparam int CROSS_I = TOP_LINE + STEP;
  localparam int ONE_I   = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLY   = 2'd1;
  localparam logic [1:0] ST_CRASH = 2'd2;

  localparam logic [POS_W:0]     LP_CROSS    = CROSS_I[POS_W:0];
  localparam logic [POS_W:0]     LP_BOTTOM_E = BOTTOM_LINE[POS_W:0];
  localparam logic [POS_W:0]     LP_STEP_E   = STEP[POS_W:0];
  localparam logic [POS_W-1:0]   LP_BOTTOM   = BOTTOM_LINE[POS_W-1:0];
  localparam logic [POS_W-1:0]   LP_STEP     = STEP[POS_W-1:0];
  localparam logic [SCORE_W-1:0] LP_MAX      = MAX_SCORE[SCORE_W-1:0];
  localparam logic [SCORE_W-1:0] LP_ONE_S    = ONE_I[SCORE_W-1:0];
  localparam logic [HOLD_W-1:0]  LP_HOLD     = CRASH_HOLD[HOLD_W-1:0];
  localparam logic [HOLD_W-1:0]  LP_ONE_H    = ONE_I[HOLD_W-1:0];

  logic r_game_q;
  logic w_rise;
  logic w_fall;

  logic [POS_W-1:0]   w_pos_a     [NUM_PLAYERS];
  logic [SCORE_W-1:0] w_score_a   [NUM_PLAYERS];
  logic [1:0]         w_state_a   [NUM_PLAYERS];
  logic               w_pulse_a   [NUM_PLAYERS];
  logic               w_crashed_a [NUM_PLAYERS];
  logic               w_on_a      [NUM_PLAYERS];

  assign w_rise = bus.GAME_ON & ~r_game_q;
  assign w_fall = ~bus.GAME_ON & r_game_q;

  always_ff @(posedge CLK_SRC or posedge RESET) begin
    if (RESET) r_game_q <= 1'b0;
    else       r_game_q <= bus.GAME_ON;
  end

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_ch
    logic [1:0]         r_state, w_state_nxt;
    logic [POS_W-1:0]   r_pos, w_pos_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
    logic               r_pulse, w_pulse_nxt;
    logic               r_crashed, r_on;
    logic               w_up, w_dn;
    logic [POS_W:0]     w_pos_ext, w_down_sum;

    assign w_up       = ~bus.UP_N[gi] & bus.DOWN_N[gi];
    assign w_dn       = ~bus.DOWN_N[gi] & bus.UP_N[gi];
    assign w_pos_ext  = {1'b0, r_pos};
    assign w_down_sum = w_pos_ext + LP_STEP_E;

    always_comb begin
      w_state_nxt = r_state;
      w_pos_nxt   = r_pos;
      w_score_nxt = r_score;
      w_hold_nxt  = r_hold;
      w_pulse_nxt = 1'b0;
      if (w_fall) begin
        w_state_nxt = ST_IDLE;
        w_pos_nxt   = LP_BOTTOM;
        w_hold_nxt  = '0;
      end else begin
        if (w_rise) w_score_nxt = '0;
        case (r_state)
          ST_IDLE: begin
            w_pos_nxt = LP_BOTTOM;
            if (bus.GAME_ON) w_state_nxt = ST_FLY;
          end
          ST_FLY: begin
            // Crash is checked first so it beats a same-tick top-line crossing.
            if (bus.CRASH[gi]) begin
              w_state_nxt = ST_CRASH;
              w_pos_nxt   = LP_BOTTOM;
              w_hold_nxt  = LP_HOLD;
            end else if (bus.FRAME_TICK) begin
              if (w_up && (w_pos_ext <= LP_CROSS)) begin
                w_pos_nxt   = LP_BOTTOM;
                w_pulse_nxt = 1'b1;
                if (w_score_nxt < LP_MAX) w_score_nxt = w_score_nxt + LP_ONE_S;
              end else if (w_up) begin
                w_pos_nxt = r_pos - LP_STEP;
              end else if (w_dn) begin
                w_pos_nxt = (w_down_sum >= LP_BOTTOM_E) ? LP_BOTTOM : w_down_sum[POS_W-1:0];
              end
            end
          end
          ST_CRASH: begin
            if (bus.FRAME_TICK) begin
              if (r_hold <= LP_ONE_H) begin
                w_state_nxt = ST_FLY;
                w_hold_nxt  = '0;
              end else begin
                w_hold_nxt = r_hold - LP_ONE_H;
              end
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_pos_nxt   = LP_BOTTOM;
          end
        endcase
      end
    end

    always_ff @(posedge CLK_SRC or posedge RESET) begin
      if (RESET) begin
        r_state   <= ST_IDLE;
        r_pos     <= LP_BOTTOM;
        r_score   <= '0;
        r_hold    <= '0;
        r_pulse   <= 1'b0;
        r_crashed <= 1'b0;
        r_on      <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_pos     <= w_pos_nxt;
        r_score   <= w_score_nxt;
        r_hold    <= w_hold_nxt;
        r_pulse   <= w_pulse_nxt;
        r_crashed <= (w_state_nxt == ST_CRASH);
        r_on      <= (w_state_nxt == ST_FLY);
      end
    end

    assign w_pos_a[gi]     = r_pos;
    assign w_score_a[gi]   = r_score;
    assign w_state_a[gi]   = r_state;
    assign w_pulse_a[gi]   = r_pulse;
    assign w_crashed_a[gi] = r_crashed;
    assign w_on_a[gi]      = r_on;
  end

  always_comb begin
    bus.POS         = '0;
    bus.SCORE       = '0;
    bus.DBG_STATE   = '0;
    bus.SCORE_PULSE = '0;
    bus.CRASHED     = '0;
    bus.ROCKET_ON   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      bus.POS[i*POS_W +: POS_W]       = w_pos_a[i];
      bus.SCORE[i*SCORE_W +: SCORE_W] = w_score_a[i];
      bus.DBG_STATE[i*2 +: 2]         = w_state_a[i];
      bus.SCORE_PULSE[i]              = w_pulse_a[i];
      bus.CRASHED[i]                  = w_crashed_a[i];
      bus.ROCKET_ON[i]                = w_on_a[i];
    end
  end

endmodule
